// File: rtl/nano_rv32i_pkg.sv
// -----------------------------------------------------------------------------
// nano_rv32i_pkg
// Shared definitions for the nano_rv32i memory arbiter.
//   - arb_state_e : arbiter FSM states (ST_IDLE / ST_BUSY / ST_RESP)
//   - arb_gnt_e   : grant codes (GNT_I = fetch port, GNT_D = data port)
//   - FETCH_BE    : byte enables used for every instruction fetch
//   - TIMEOUT_DATA: read data returned for an access aborted by timeout
//   - mem_cmd_t   : one captured memory command (we / be / addr / wdata)
//   - fetch_cmd() / data_cmd() build a mem_cmd_t from a master's inputs
// -----------------------------------------------------------------------------
package nano_rv32i_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Grant code doubles as the bit index of that master in the request vector.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

    localparam logic [3:0]  FETCH_BE     = 4'hF;
    localparam logic [31:0] TIMEOUT_DATA = 32'h0000_0000;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Fetches are always full-word reads from the word-aligned address.
    function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
        mem_cmd_t c;
        c.we    = 1'b0;
        c.be    = FETCH_BE;
        c.addr  = {addr[31:2], 2'b00};
        c.wdata = 32'h0000_0000;
        return c;
    endfunction

    // Data accesses go to memory exactly as the core presented them.
    function automatic mem_cmd_t data_cmd(input logic        we,
                                          input logic [3:0]  be,
                                          input logic [31:0] addr,
                                          input logic [31:0] wdata);
        mem_cmd_t c;
        c.we    = we;
        c.be    = be;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/nano_rr_arb2.sv
// -----------------------------------------------------------------------------
// nano_rr_arb2
// Combinational two-requester round-robin picker.
// Ports:
//   req[1:0]  in   request vector, indexed by grant code (bit0 = I, bit1 = D)
//   last_gnt  in   master granted most recently (flop lives in the parent)
//   gnt       out  chosen master (meaningful only when valid=1)
//   valid     out  at least one request present
// -----------------------------------------------------------------------------
module nano_rr_arb2
    import nano_rv32i_pkg::*;
(
    input  logic [1:0] req,
    input  arb_gnt_e   last_gnt,
    output arb_gnt_e   gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = last_gnt;
        case (req)
            2'b01:   gnt = GNT_I;
            2'b10:   gnt = GNT_D;
            // Contention: whoever did not win last time goes next.
            2'b11:   gnt = (last_gnt == GNT_I) ? GNT_D : GNT_I;
            default: gnt = last_gnt;
        endcase
    end

endmodule

// File: rtl/nano_mem_arb.sv
// -----------------------------------------------------------------------------
// nano_mem_arb
// Two-master (instruction fetch / data load-store) single-port memory arbiter.
// A granted request is captured into the m_* registers, held on the memory bus
// until m_ack_i, then the winner gets a one-cycle ack with its read data.
// Throughput is one transaction every three cycles at best (IDLE-BUSY-RESP).
//
// Optional feature macro: NANO_ARB_TIMEOUT_EN
//   defined   : BUSY aborts after TIMEOUT_CYCLES cycles without m_ack_i;
//               ack is returned with err=1 and read data TIMEOUT_DATA.
//   undefined : i_err_o = d_err_o = 0, BUSY waits forever.
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   i_req_i, i_addr_i         fetch request / byte address
//   i_data_o, i_ack_o, i_err_o fetch data, one-cycle ack, timeout flag
//   d_req_i, d_we_i, d_be_i,
//   d_addr_i, d_wdata_i       data request and command
//   d_rdata_o, d_ack_o, d_err_o load data, one-cycle ack, timeout flag
//   m_req_o, m_we_o, m_be_o,
//   m_addr_o, m_wdata_o       shared memory command (held until m_ack_i)
//   m_rdata_i, m_ack_i        memory response (ack honoured only in BUSY)
// -----------------------------------------------------------------------------
module nano_mem_arb
    import nano_rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // fetch port
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] i_data_o,
    output logic        i_ack_o,
    output logic        i_err_o,
    // data port
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ack_o,
    output logic        d_err_o,
    // memory port
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_ack_i
);

    arb_state_e  r_state;
    arb_state_e  w_state_next;
    // Updated on every grant, so it also names the master currently in flight.
    arb_gnt_e    r_last_gnt;
    arb_gnt_e    w_arb_gnt;
    logic        w_arb_valid;

    logic        w_capture;
    logic        w_complete;
    logic        w_abort;
    logic        w_timeout_hit;

    mem_cmd_t    r_cmd;
    mem_cmd_t    w_cmd_sel;
    logic        r_m_req;
    logic        r_i_ack;
    logic        r_d_ack;
    logic [31:0] r_i_data;
    logic [31:0] r_d_rdata;

    nano_rr_arb2 u_rr_arb2 (
        .req      ({d_req_i, i_req_i}),
        .last_gnt (r_last_gnt),
        .gnt      (w_arb_gnt),
        .valid    (w_arb_valid)
    );

    always_comb begin
        if (w_arb_gnt == GNT_D) begin
            w_cmd_sel = data_cmd(d_we_i, d_be_i, d_addr_i, d_wdata_i);
        end else begin
            w_cmd_sel = fetch_cmd(i_addr_i);
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A memory ack in the timeout cycle is a normal completion.
                if (m_ack_i) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_RESP;
                end else if (w_timeout_hit) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // Requests are deliberately not looked at here: the master
                // only drops its request after seeing the ack.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath / registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_gnt <= GNT_I;
            r_cmd      <= '0;
            r_m_req    <= 1'b0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            r_i_data   <= 32'h0000_0000;
            r_d_rdata  <= 32'h0000_0000;
        end else begin
            if (w_capture) begin
                r_cmd      <= w_cmd_sel;
                r_last_gnt <= w_arb_gnt;
            end

            if (w_capture) begin
                r_m_req <= 1'b1;
            end else if (w_complete || w_abort) begin
                r_m_req <= 1'b0;
            end

            // Set only on the BUSY->RESP transition, so each ack is one cycle.
            r_i_ack <= (w_complete || w_abort) && (r_last_gnt == GNT_I);
            r_d_ack <= (w_complete || w_abort) && (r_last_gnt == GNT_D);

            // Stores never touch d_rdata_o; read data is held between accesses.
            if (w_complete) begin
                if (r_last_gnt == GNT_I) begin
                    r_i_data <= m_rdata_i;
                end else if (!r_cmd.we) begin
                    r_d_rdata <= m_rdata_i;
                end
            end else if (w_abort) begin
                if (r_last_gnt == GNT_I) begin
                    r_i_data <= TIMEOUT_DATA;
                end else if (!r_cmd.we) begin
                    r_d_rdata <= TIMEOUT_DATA;
                end
            end
        end
    end

`ifdef NANO_ARB_TIMEOUT_EN
    // At least 8 bits, wide enough to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_i_err;
    logic             r_d_err;

    // r_cnt counts completed ack-less BUSY cycles; the abort happens in the
    // BUSY cycle that would bring it to TIMEOUT_CYCLES.
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_timeout_hit = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_i_err <= 1'b0;
            r_d_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cnt <= '0;
            end else if ((r_state == ST_BUSY) && !m_ack_i) begin
                r_cnt <= w_cnt_inc;
            end
            r_i_err <= w_abort && (r_last_gnt == GNT_I);
            r_d_err <= w_abort && (r_last_gnt == GNT_D);
        end
    end

    assign i_err_o = r_i_err;
    assign d_err_o = r_d_err;
`else
    // No watchdog in this build; the parameter is kept so both builds share
    // one interface.
    assign w_timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign i_err_o       = 1'b0;
    assign d_err_o       = 1'b0;
`endif

    assign i_data_o  = r_i_data;
    assign i_ack_o   = r_i_ack;
    assign d_rdata_o = r_d_rdata;
    assign d_ack_o   = r_d_ack;
    assign m_req_o   = r_m_req;
    assign m_we_o    = r_cmd.we;
    assign m_be_o    = r_cmd.be;
    assign m_addr_o  = r_cmd.addr;
    assign m_wdata_o = r_cmd.wdata;

endmodule
